// File: rtl/clk_ui_pkg.sv
// Shared definitions for the clock user-interface blocks.
// Holds the button channel FSM state type, the channel index constants
// (bit 0 = sec, bit 1 = min, bit 2 = hour) and the default channel count.
package clk_ui_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  localparam int BTN_SEC      = 0;
  localparam int BTN_MIN      = 1;
  localparam int BTN_HOUR     = 2;
  localparam int NBTN_DEFAULT = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One time-set button channel: 2-FF synchronizer, debounce, rising-edge
// one-shot and hold-to-auto-repeat.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   open        - 1 = clock running, presses ignored; 0 = set mode
//   btn_raw     - asynchronous raw button, active-high
//   add_pulse   - registered one-cycle increment request
//   btn_level   - debounced button level
//   state       - current FSM state (debug / checker visibility)
module btn_channel
  import clk_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       open,
  input  logic       btn_raw,
  output logic       add_pulse,
  output logic       btn_level,
  output btn_state_t state
);

  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam int TW_RAW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST   = TW'(REPEAT_PERIOD - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  btn_state_t    state_nxt;
  logic          pulse_nxt;
  logic          rise;

  // Synchronizer and debounce. The counter only advances while the
  // synchronized level disagrees with the accepted level, so any glitch
  // shorter than the debounce window collapses back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise      = stable & ~stable_d;
  assign btn_level = stable;

  // State register (also registers the pulse so add_pulse is glitch-free).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      add_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      add_pulse <= pulse_nxt;
    end
  end

  // Next-state and timer. Only a fresh rise while in set mode starts a
  // sequence, so dropping open while already held never fires.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      ST_IDLE: begin
        if (rise && !open) begin
          state_nxt = ST_HELD;
          timer_nxt = '0;
        end
      end
      ST_HELD: begin
        if (!stable || open) begin
          state_nxt = ST_IDLE;
        end else if (timer == DELAY_LAST) begin
          state_nxt = ST_REPEAT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!stable || open) begin
          state_nxt = ST_IDLE;
        end else if (timer == PER_LAST) begin
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Pulse request for the coming edge.
  always_comb begin
    pulse_nxt = 1'b0;
    unique case (state)
      ST_IDLE:   pulse_nxt = rise && !open;
      ST_HELD:   pulse_nxt = stable && !open && (timer == DELAY_LAST);
      ST_REPEAT: pulse_nxt = stable && !open && (timer == PER_LAST);
      default:   pulse_nxt = 1'b0;
    endcase
  end

endmodule

// File: rtl/set_btn_ctrl.sv
// Time-set button conditioner: one btn_channel per button, outputs are
// single-cycle pulses synchronous to clk, suppressed while open=1.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   open           - 1 = clock running; 0 = set mode
//   btn_raw        - raw buttons (bit 0 sec, bit 1 min, bit 2 hour)
//   add_pulse      - one-cycle increment request per channel
//   btn_level      - debounced levels
//   repeat_active  - 1 while the channel is auto-repeating
module set_btn_ctrl
  import clk_ui_pkg::*;
#(
  parameter int NBTN            = NBTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            open,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] add_pulse,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] repeat_active
);

  btn_state_t chan_state [NBTN];

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .open     (open),
      .btn_raw  (btn_raw[i]),
      .add_pulse(add_pulse[i]),
      .btn_level(btn_level[i]),
      .state    (chan_state[i])
    );

    // Direct decode of the channel's state flops.
    assign repeat_active[i] = (chan_state[i] == ST_REPEAT);
  end

endmodule

// File: tb/tb_set_btn_ctrl.sv
module tb_set_btn_ctrl;

  localparam int NB = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic open;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] add_pulse;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] repeat_active;

  always #5 clk = ~clk;

  set_btn_ctrl #(
    .NBTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .open         (open),
    .btn_raw      (btn_raw),
    .add_pulse    (add_pulse),
    .btn_level    (btn_level),
    .repeat_active(repeat_active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: raw history, accepted level, run length of
  // disagreement, and for each active press the edges since its first pulse.
  logic [NB-1:0] m_h1, m_h2, m_stable, m_stable_d, m_active, m_pulse, m_rep;
  int m_run [NB];
  int m_age [NB];

  task automatic model_step();
    if (reset) begin
      m_h1 = '0; m_h2 = '0; m_stable = '0; m_stable_d = '0;
      m_active = '0; m_pulse = '0; m_rep = '0;
      for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_age[c] = 0; end
    end else begin
      for (int c = 0; c < NB; c++) begin
        logic old_st, old_d, seen;
        old_st = m_stable[c];
        old_d  = m_stable_d[c];
        m_pulse[c] = 1'b0;
        if (!m_active[c]) begin
          if (old_st && !old_d && !open) begin
            m_active[c] = 1'b1; m_age[c] = 0; m_pulse[c] = 1'b1;
          end
        end else if (!old_st || open) begin
          m_active[c] = 1'b0;
        end else begin
          m_age[c]++;
          m_pulse[c] = (m_age[c] == RD) || (m_age[c] > RD && ((m_age[c] - RD) % RP) == 0);
        end
        m_rep[c] = m_active[c] && (m_age[c] >= RD);
        // the debounce stage sees the raw level from two edges back
        seen = m_h2[c];
        if (seen == old_st) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == DB) begin m_stable[c] = seen; m_run[c] = 0; end
        end
        m_stable_d[c] = old_st;
      end
      m_h2 = m_h1;
      m_h1 = btn_raw;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("add_pulse", 32'(add_pulse), 32'(m_pulse));
    check_eq("btn_level", 32'(btn_level), 32'(m_stable));
    check_eq("repeat_active", 32'(repeat_active), 32'(m_rep));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int hold [NB];

  initial begin
    reset = 1'b1; open = 1'b0; btn_raw = '0;
    ticks(2);
    check_eq("rst_pulse", 32'(add_pulse), 32'd0);
    check_eq("rst_level", 32'(btn_level), 32'd0);
    check_eq("rst_repeat", 32'(repeat_active), 32'd0);
    reset = 1'b0;
    ticks(3);

    // short glitch is rejected
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("glitch_level", 32'(btn_level[0]), 32'd0);
    end
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("glitch_level", 32'(btn_level[0]), 32'd0);
      check_eq("glitch_pulse", 32'(add_pulse), 32'd0);
    end

    // single press: level after edge 5, pulse after edge 6 only
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t2_pulse", 32'(add_pulse[1]), 32'(i == 6));
      check_eq("t2_level", 32'(btn_level[1]), 32'(i >= 5 && i < 13));
      if (i == 7) btn_raw[1] = 1'b0;
    end

    // long hold into auto-repeat
    btn_raw[2] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      logic ep;
      tick();
      ep = (i == 6) || (i == 16) || (i == 21) || (i == 26) || (i == 31) || (i == 36) || (i == 41);
      check_eq("t3_pulse", 32'(add_pulse[2]), 32'(ep));
      check_eq("t3_repeat", 32'(repeat_active[2]), 32'(i >= 16 && i <= 45));
      if (i == 39) btn_raw[2] = 1'b0;
    end

    // presses ignored while open, no pulse when open drops mid-hold
    open = 1'b1; btn_raw[0] = 1'b1;
    ticks(20);
    check_eq("t4_level", 32'(btn_level[0]), 32'd1);
    open = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t4_nopulse", 32'(add_pulse), 32'd0);
    end
    btn_raw[0] = 1'b0;
    ticks(10);
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t4_repress", 32'(add_pulse[0]), 32'(i == 6));
    end

    // reset mid-repeat with the button still down
    ticks(15);
    check_eq("t5_in_repeat", 32'(repeat_active[0]), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("t5_rst_out", 32'({add_pulse, btn_level, repeat_active}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t5_restart", 32'(add_pulse[0]), 32'(i == 6));
    end
    btn_raw = '0;
    ticks(12);

    // simultaneous presses
    btn_raw = 3'b101;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 6 || i == 16 || i == 21 || i == 26)
        check_eq("t6_both", 32'(add_pulse), 32'b101);
    end
    btn_raw = '0;
    ticks(12);

    // randomized: per-channel hold lengths, occasional open toggles / reset
    for (int c = 0; c < NB; c++) hold[c] = $urandom_range(1, 25);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NB; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn_raw[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end
      end
      if ($urandom_range(0, 60) == 0) open = ~open;
      reset = ($urandom_range(0, 400) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
